// File: rtl/acc_out_requant.sv
// acc_out_requant
//   Drain-side requantizer for the MAC accumulator chain. Each accepted
//   O_CONV_BW-bit signed partial sum gets a per-channel bias added, is
//   rounded and arithmetically right-shifted, and is clamped to an I_BW-bit
//   activation. The result is pushed into a small FIFO that drives a
//   valid/ready output stream.
//
//   Pipeline: S1 bias add -> S2 round/shift -> S3 clamp -> FIFO write.
//   An input accepted at edge N lands in the FIFO at edge N+3.
//   The pipeline never stalls. in_ready grants a credit only while the
//   FIFO plus everything in flight still fits in DEPTH, so an S3 push
//   always finds space.
//
//   Build option: define ACC_RELU_EN to clamp to [0, 2^(I_BW-1)-1]. Without
//   it the clamp is signed saturation to [-2^(I_BW-1), 2^(I_BW-1)-1].
//
// Ports
//   clk, global_rst          clock (rising edge), async active-high reset
//   clr                      sync flush of pipeline, FIFO and channel index;
//                            the bias registers keep their values
//   in_valid/in_ready        input handshake
//   in_data, in_last         accumulator value, end of channel group
//   cfg_shift                right shift, captured with each accepted input
//   bias_we/addr/wdata       bias register write port
//   out_valid/out_ready      output handshake (out_valid = FIFO non-empty)
//   out_data, out_last       FIFO head entry (out_data is 0 when empty)
//   fifo_count               FIFO occupancy
module acc_out_requant #(
   parameter int O_CONV_BW = 20,
   parameter int I_BW      = 8,
   parameter int B_BW      = 16,
   parameter int SHIFT_BW  = 5,
   parameter int CH_NUM    = 4,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        global_rst,
   input  logic                        clr,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [O_CONV_BW-1:0]        in_data,
   input  logic                        in_last,
   input  logic [SHIFT_BW-1:0]         cfg_shift,
   input  logic                        bias_we,
   input  logic [$clog2(CH_NUM)-1:0]   bias_addr,
   input  logic [B_BW-1:0]             bias_wdata,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [I_BW-1:0]             out_data,
   output logic                        out_last,
   output logic [$clog2(DEPTH):0]      fifo_count
);

   localparam int STAGES = 3;
   localparam int AW     = $clog2(CH_NUM);
   localparam int SW     = O_CONV_BW + 1;   // S1 sum width
   localparam int RW     = O_CONV_BW + 2;   // headroom for the rounding add
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = PW + 1;

   localparam logic signed [RW-1:0] SAT_HI = RW'((1 << (I_BW-1)) - 1);
`ifdef ACC_RELU_EN
   localparam logic signed [RW-1:0] SAT_LO = '0;
`else
   localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;
`endif

   // ------------------------------------------------------------------
   // Handshake and channel bookkeeping
   // ------------------------------------------------------------------
   logic [STAGES:1]         vld_pipe_q;
   logic [CW-1:0]           count_q;
   logic [CW:0]             occ;
   logic                    accept;
   logic [AW-1:0]           ch_idx_q;
   logic signed [B_BW-1:0]  bias_q [CH_NUM];

   // Credits count everything already committed to the FIFO.
   always_comb begin
      occ = {1'b0, count_q}
          + {{CW{1'b0}}, vld_pipe_q[1]}
          + {{CW{1'b0}}, vld_pipe_q[2]}
          + {{CW{1'b0}}, vld_pipe_q[3]};
   end

   assign in_ready = (occ < (CW+1)'(DEPTH));
   assign accept   = in_valid & in_ready & ~clr;

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         ch_idx_q <= '0;
      end else if (clr) begin
         ch_idx_q <= '0;
      end else if (accept) begin
         if (in_last || ch_idx_q == AW'(CH_NUM-1))
            ch_idx_q <= '0;
         else
            ch_idx_q <= ch_idx_q + 1'b1;
      end
   end

   // Writes are not blocked by clr; only global_rst clears the biases.
   // The S1 add reads bias_q directly, so a same-cycle write is not seen.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         for (int i = 0; i < CH_NUM; i++) bias_q[i] <= '0;
      end else if (bias_we && 32'(bias_addr) < CH_NUM) begin
         bias_q[bias_addr] <= bias_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   logic signed [SW-1:0]       s1_sum_d, s1_sum_q;
   logic                       s1_last_q;
   logic [SHIFT_BW-1:0]        s1_shift_q;
   logic signed [RW-1:0]       s2_r_d, s2_r_q;
   logic                       s2_last_q;
   logic [I_BW-1:0]            s3_data_d, s3_data_q;
   logic                       s3_last_q;

   logic [SHIFT_BW-1:0]        sh;
   logic signed [RW-1:0]       ext, half, rnd;
   logic signed [B_BW-1:0]     bias_rd;

   always_comb begin
      bias_rd  = bias_q[ch_idx_q];
      s1_sum_d = {in_data[O_CONV_BW-1], in_data}
               + {{(SW-B_BW){bias_rd[B_BW-1]}}, bias_rd};
   end

   // Round half up: add 2^(sh-1) then shift arithmetically.
   always_comb begin
      sh = (32'(s1_shift_q) > O_CONV_BW) ? SHIFT_BW'(O_CONV_BW) : s1_shift_q;
      ext  = {s1_sum_q[SW-1], s1_sum_q};
      half = (sh == '0) ? '0 : (RW'(1) << (sh - 1'b1));
      rnd  = ext + half;
      s2_r_d = rnd >>> sh;
   end

   always_comb begin
      if (s2_r_q > SAT_HI)
         s3_data_d = SAT_HI[I_BW-1:0];
      else if (s2_r_q < SAT_LO)
         s3_data_d = SAT_LO[I_BW-1:0];
      else
         s3_data_d = s2_r_q[I_BW-1:0];
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         vld_pipe_q <= '0;
         s1_sum_q   <= '0;
         s1_last_q  <= 1'b0;
         s1_shift_q <= '0;
         s2_r_q     <= '0;
         s2_last_q  <= 1'b0;
         s3_data_q  <= '0;
         s3_last_q  <= 1'b0;
      end else begin
         vld_pipe_q <= clr ? '0 : {vld_pipe_q[STAGES-1:1], accept};
         s1_sum_q   <= s1_sum_d;
         s1_last_q  <= in_last;
         s1_shift_q <= cfg_shift;
         s2_r_q     <= s2_r_d;
         s2_last_q  <= s1_last_q;
         s3_data_q  <= s3_data_d;
         s3_last_q  <= s2_last_q;
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   logic [I_BW-1:0] mem_data_q [DEPTH];
   logic            mem_last_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic            push, pop;

   assign push      = vld_pipe_q[STAGES] & ~clr;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready & ~clr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_last_q[i] <= 1'b0;
         end
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_data_q[wr_ptr_q] <= s3_data_q;
            mem_last_q[wr_ptr_q] <= s3_last_q;
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
      end
   end

   assign out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
   assign out_last   = out_valid ? mem_last_q[rd_ptr_q] : 1'b0;
   assign fifo_count = count_q;

   // Credits guarantee the FIFO is never full when S3 delivers.
   a_no_push_full : assert property (@(posedge clk) disable iff (global_rst)
      !(vld_pipe_q[STAGES] && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_acc_out_requant.sv
module tb_acc_out_requant;
   localparam int OBW = 20, IBW = 8, BBW = 16, SBW = 5, CHN = 4, DEP = 4;
`ifdef ACC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           global_rst, clr, in_valid, in_ready, in_last;
   logic [OBW-1:0] in_data;
   logic [SBW-1:0] cfg_shift;
   logic           bias_we;
   logic [1:0]     bias_addr;
   logic [BBW-1:0] bias_wdata;
   logic           out_valid, out_ready, out_last;
   logic [IBW-1:0] out_data;
   logic [2:0]     fifo_count;

   always #5 clk = ~clk;

   acc_out_requant #(.O_CONV_BW(OBW), .I_BW(IBW), .B_BW(BBW), .SHIFT_BW(SBW),
                     .CH_NUM(CHN), .DEPTH(DEP)) dut (
      .clk(clk), .global_rst(global_rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .cfg_shift(cfg_shift),
      .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .fifo_count(fifo_count));

   int nchk = 0, npass = 0;

   function automatic void chk(string nm, longint act, longint exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endfunction

   // Reference: plain integer arithmetic from the requantization rules.
   function automatic longint ref_out(longint d, longint b, int shift);
      longint s, r, hi, lo;
      int k;
      s  = d + b;
      k  = (shift > OBW) ? OBW : shift;
      r  = (k == 0) ? s : ((s + (longint'(1) << (k-1))) >>> k);
      hi = (1 << (IBW-1)) - 1;
      lo = RELU ? 0 : -(1 << (IBW-1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   typedef struct { longint d; bit l; } exp_t;
   exp_t   q[$];
   longint pop_d[$];
   bit     pop_l[$];
   longint mbias[CHN];
   int     mch = 0, n_acc = 0, n_pop = 0;
   exp_t   me;

   // Scoreboard: evaluated at the falling edge, i.e. on the values that the
   // next rising edge will act on.
   always @(negedge clk) begin
      if (global_rst || clr) begin
         q.delete();
         mch = 0;
         if (global_rst) foreach (mbias[i]) mbias[i] = 0;
      end else begin
         if (out_valid && out_ready) begin
            n_pop++;
            pop_d.push_back(longint'($signed(out_data)));
            pop_l.push_back(out_last);
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
               me = q.pop_front();
               chk("stream_data", longint'($signed(out_data)), me.d);
               chk("stream_last", longint'(out_last), longint'(me.l));
            end
         end
         if (in_valid && in_ready) begin
            n_acc++;
            me.d = ref_out(longint'($signed(in_data)), mbias[mch], int'(cfg_shift));
            me.l = in_last;
            q.push_back(me);
            mch = in_last ? 0 : ((mch == CHN-1) ? 0 : mch + 1);
         end
         if (bias_we) mbias[bias_addr] = longint'($signed(bias_wdata));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated input; checks the exact 3-edge latency to out_valid.
   task automatic send_one(string nm, int d, int sh, longint exp);
      in_data = OBW'(d); cfg_shift = SBW'(sh); in_last = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk({nm, "_early"}, longint'(out_valid), 0);
      tick();
      chk({nm, "_valid"}, longint'(out_valid), 1);
      chk({nm, "_data"}, longint'($signed(out_data)), exp);
   endtask

   task automatic drain();
      int t = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      while ((out_valid || q.size() != 0) && t < 50) begin tick(); t++; end
      chk("drain_timeout", longint'(t < 50), 1);
   endtask

   typedef struct { int d; int sh; longint exp_s; longint exp_r; } vec_t;
   vec_t   tv[4];
   int     bv[4];
   longint vals[6];
   int     k, p0, a0, o0, t;
   bit     r;
   int     dseq[4];
   bit     lseq[4];

   initial begin
      // channel order 0..3 follows the channel counter
      tv[0] = '{246,  4,   16,  16};
      tv[1] = '{-100, 4,   -7,   0};
      tv[2] = '{-300, 0, -128,   0};
      tv[3] = '{5000, 4,  127, 127};
      bv    = '{10, -5, 0, 100};
      dseq  = '{246, -100, 0, 246};
      lseq  = '{1'b0, 1'b0, 1'b1, 1'b0};

      global_rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; cfg_shift = '0; bias_we = 1'b0; bias_addr = '0;
      bias_wdata = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 global_rst = 1'b0;

      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_last", longint'(out_last), 0);
      chk("rst_fifo_count", longint'(fifo_count), 0);
      chk("rst_in_ready", longint'(in_ready), 1);

      for (int i = 0; i < 4; i++) begin
         bias_we = 1'b1; bias_addr = 2'(i); bias_wdata = BBW'(bv[i]);
         tick();
      end
      bias_we = 1'b0;

      // directed vectors
      for (int i = 0; i < 4; i++)
         send_one($sformatf("vec%0d", i), tv[i].d, tv[i].sh,
                  RELU ? tv[i].exp_r : tv[i].exp_s);
      tick();

      // backpressure: 6 held inputs, only 4 credits with the output blocked
      for (int i = 0; i < 6; i++) vals[i] = longint'($urandom_range(0, 8000)) - 4000;
      a0 = n_acc; o0 = n_pop; k = 0;
      out_ready = 1'b0; cfg_shift = SBW'($urandom_range(0, 6));
      in_valid = 1'b1; in_data = OBW'(vals[0]);
      for (int c = 0; c < 8; c++) begin
         r = in_ready; tick();
         if (r) begin k++; in_data = OBW'(vals[(k < 6) ? k : 5]); end
      end
      chk("bp_accepted", k, 4);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_fifo_count", longint'(fifo_count), 4);
      out_ready = 1'b1; t = 0;
      while (k < 6 && t < 40) begin
         r = in_ready; tick(); t++;
         if (r) begin k++; if (k < 6) in_data = OBW'(vals[k]); end
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", k, 6);
      drain();
      chk("bp_acc_count", n_acc - a0, 6);
      chk("bp_out_count", n_pop - o0, 6);

      // random traffic with random output stalls and bias updates
      for (int c = 0; c < 400; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = ($urandom_range(0, 3) == 0) ? OBW'($urandom)
                 : OBW'(int'($urandom_range(0, 6000)) - 3000);
         cfg_shift = SBW'($urandom_range(0, 31));
         in_last = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         bias_we = ($urandom_range(0, 15) == 0);
         bias_addr = 2'($urandom_range(0, 3));
         bias_wdata = BBW'($urandom);
         tick();
         if (fifo_count > 3'(DEP)) chk("fifo_overrun", longint'(fifo_count), DEP);
      end
      bias_we = 1'b0; in_last = 1'b0;
      drain();
      chk("rand_model_empty", q.size(), 0);
      chk("rand_balance", n_acc, n_pop);

      // restore the setup biases, then in_last restarts the channel count
      for (int i = 0; i < 4; i++) begin
         bias_we = 1'b1; bias_addr = 2'(i); bias_wdata = BBW'(bv[i]);
         tick();
      end
      bias_we = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      p0 = pop_d.size();
      cfg_shift = SBW'(4); out_ready = 1'b1; in_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_data = OBW'(dseq[j]); in_last = lseq[j];
         bias_we = (j == 3); bias_addr = 2'd0; bias_wdata = BBW'(50);
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0; bias_we = 1'b0;
      drain();
      chk("last_count", pop_d.size() - p0, 4);
      if (pop_d.size() - p0 == 4) begin
         for (int j = 0; j < 4; j++)
            chk($sformatf("last_flag%0d", j), longint'(pop_l[p0+j]), longint'(lseq[j]));
         chk("last_d0", pop_d[p0], 16);
         chk("last_d1", pop_d[p0+1], RELU ? 0 : -7);
         chk("last_d2", pop_d[p0+2], 0);
         chk("last_d3_oldbias", pop_d[p0+3], 16);
      end

      // clr with two buffered entries; bias[0] is now 50 and must survive
      out_ready = 1'b0; cfg_shift = '0; in_data = '0; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("clr_pre_count", longint'(fifo_count), 2);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_out_valid", longint'(out_valid), 0);
      chk("clr_fifo_count", longint'(fifo_count), 0);
      chk("clr_out_data", longint'(out_data), 0);
      chk("clr_in_ready", longint'(in_ready), 1);
      out_ready = 1'b1;
      send_one("clr_bias", 0, 0, 50);
      tick();

      // global reset with two buffered entries; bias returns to 0
      out_ready = 1'b0; cfg_shift = '0; in_data = '0; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("rst2_pre_count", longint'(fifo_count), 2);
      global_rst = 1'b1;
      #1;
      chk("rst2_async_valid", longint'(out_valid), 0);
      chk("rst2_async_count", longint'(fifo_count), 0);
      tick();
      global_rst = 1'b0;
      chk("rst2_in_ready", longint'(in_ready), 1);
      chk("rst2_out_data", longint'(out_data), 0);
      chk("rst2_out_last", longint'(out_last), 0);
      out_ready = 1'b1;
      send_one("rst2_nobias", 160, 4, 10);
      drain();
      chk("final_model_empty", q.size(), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
